// File: rtl/control_pipe.sv
// control_pipe: registered, hazard-aware main control for the MIPS pipeline.
// Decodes the ID instruction, latches the EX/MEM/WB control bundle into the
// ID/EX boundary, raises a load-use stall and runs a drain-then-halt sequence.
module control_pipe #(
  parameter int N_BITS       = 32,
  parameter int N_BITS_OP    = 6,
  parameter int N_BITS_REG   = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter logic [N_BITS_OP-1:0] HALT_OPCODE = 6'b111111
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [N_BITS-1:0]     i_instruccion,
  input  logic                  i_flush,
  input  logic                  i_idex_memRead,
  input  logic [N_BITS_REG-1:0] i_idex_rt,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [1:0]            o_control_EX_ALUOp,
  output logic                  o_control_EX_ALUSrc,
  output logic                  o_control_EX_regDst,
  output logic                  o_control_EX_jal,
  output logic [1:0]            o_control_M_branch,
  output logic                  o_control_M_memRead,
  output logic                  o_control_M_memWrite,
  output logic                  o_control_WB_memtoReg,
  output logic                  o_control_WB_regWrite,
  output logic                  o_draining,
  output logic                  o_halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       jal;
    logic [1:0] branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Instruction fields
  logic [N_BITS_OP-1:0]  opcode;
  logic [N_BITS_REG-1:0] rs;
  logic [N_BITS_REG-1:0] rt;
  logic [15:0]           unused_imm;

  assign opcode     = i_instruccion[N_BITS-1 -: N_BITS_OP];
  assign rs         = i_instruccion[25 -: N_BITS_REG];
  assign rt         = i_instruccion[20 -: N_BITS_REG];
  assign unused_imm = i_instruccion[15:0];

  // Registered state
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              ctl_q, ctl_d;
  logic               draining_q, draining_d;
  logic               halted_q, halted_d;

  // Decode results
  ctrl_t dec;
  logic  rs_used;
  logic  rt_used;
  logic  is_halt;
  logic  stall;

  // Opcode decode into a control bundle plus source-register usage
  always_comb begin
    dec     = '0;
    rs_used = 1'b1;
    rt_used = 1'b0;
    case (opcode)
      6'b000000: begin
        dec.valid     = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        rt_used       = 1'b1;
      end
      6'b001111, 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
        dec.valid     = 1'b1;
        dec.alu_op    = 2'b10;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      6'b000100, 6'b000101: begin
        dec.valid  = 1'b1;
        dec.branch = 2'b01;
        dec.alu_op = 2'b01;
        rt_used    = 1'b1;
      end
      6'b000010: begin
        dec.valid  = 1'b1;
        dec.branch = 2'b10;
        rs_used    = 1'b0;
      end
      6'b000011: begin
        dec.valid     = 1'b1;
        dec.branch    = 2'b10;
        dec.reg_write = 1'b1;
        dec.jal       = 1'b1;
        rs_used       = 1'b0;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.valid     = 1'b1;
        dec.alu_op    = 2'b10;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        rt_used       = 1'b1;
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
        dec.valid      = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      default: ;
    endcase
    // Halt always latches as a bubble, even if it aliases a decoded class
    if (opcode == HALT_OPCODE) begin
      dec = '0;
    end
  end

  assign is_halt = (opcode == HALT_OPCODE);

  // Load-use hazard: EX load writes a register the ID instruction reads
  always_comb begin
    stall = 1'b0;
    if ((state_q == RUN) && i_valid && !i_flush && !i_reset &&
        i_idex_memRead && (i_idex_rt != '0)) begin
      stall = (rs_used && (i_idex_rt == rs)) || (rt_used && (i_idex_rt == rt));
    end
  end

  assign o_stall = stall;

  // Next bundle and halt-sequence state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = '0;
    case (state_q)
      RUN: begin
        if (i_valid && !i_flush && !stall) begin
          ctl_d = dec;
          if (is_halt) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
    draining_d = (state_d == DRAIN);
    halted_d   = (state_d == HALTED);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ctl_q      <= '0;
      draining_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctl_q      <= ctl_d;
      draining_q <= draining_d;
      halted_q   <= halted_d;
    end
  end

  assign o_valid               = ctl_q.valid;
  assign o_control_EX_ALUOp    = ctl_q.alu_op;
  assign o_control_EX_ALUSrc   = ctl_q.alu_src;
  assign o_control_EX_regDst   = ctl_q.reg_dst;
  assign o_control_EX_jal      = ctl_q.jal;
  assign o_control_M_branch    = ctl_q.branch;
  assign o_control_M_memRead   = ctl_q.mem_read;
  assign o_control_M_memWrite  = ctl_q.mem_write;
  assign o_control_WB_memtoReg = ctl_q.mem_to_reg;
  assign o_control_WB_regWrite = ctl_q.reg_write;
  assign o_draining            = draining_q;
  assign o_halted              = halted_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: expected bundles are queued as each
// vector is driven and compared once the registered outputs update.
module tb_control_pipe;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] instr;
  logic        flush;
  logic        mr;
  logic [4:0]  ex_rt;
  logic        stall;
  logic        o_valid;
  logic [1:0]  alu_op;
  logic        alu_src, reg_dst, jal;
  logic [1:0]  branch;
  logic        mem_read, mem_write, mem_to_reg, reg_write;
  logic        draining, halted;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [13:0] exp_q[$];

  // Packed order: valid, ALUOp[1:0], ALUSrc, regDst, jal, branch[1:0],
  //               memRead, memWrite, memtoReg, regWrite, draining, halted
  localparam logic [13:0] E_BUB = 14'b0_00_0_0_0_00_0_0_0_0_0_0;
  localparam logic [13:0] E_R   = 14'b1_00_0_1_0_00_0_0_0_1_0_0;
  localparam logic [13:0] E_I   = 14'b1_10_1_0_0_00_0_0_0_1_0_0;
  localparam logic [13:0] E_BR  = 14'b1_01_0_0_0_01_0_0_0_0_0_0;
  localparam logic [13:0] E_J   = 14'b1_00_0_0_0_10_0_0_0_0_0_0;
  localparam logic [13:0] E_JAL = 14'b1_00_0_0_1_10_0_0_0_1_0_0;
  localparam logic [13:0] E_SW  = 14'b1_10_1_0_0_00_0_1_0_0_0_0;
  localparam logic [13:0] E_LW  = 14'b1_00_1_0_0_00_1_0_1_1_0_0;
  localparam logic [13:0] E_DR  = 14'b0_00_0_0_0_00_0_0_0_0_1_0;
  localparam logic [13:0] E_HT  = 14'b0_00_0_0_0_00_0_0_0_0_0_1;

  localparam logic [31:0] ADD_A = 32'h012A4020; // add $t0,$t1,$t2 (rs=9, rt=10)
  localparam logic [31:0] ADD_B = 32'h010A4820; // add $t1,$t0,$t2 (rs=8, rt=10)
  localparam logic [31:0] ADDI  = 32'h21090005; // addi rs=8, rt=9
  localparam logic [31:0] BEQ   = 32'h11090003; // beq rs=8, rt=9
  localparam logic [31:0] JMP   = 32'h09000010; // j, target bits overlap rs=8
  localparam logic [31:0] JAL   = 32'h0C000010;
  localparam logic [31:0] SW    = 32'hAD090004; // sw rs=8, rt=9
  localparam logic [31:0] LW    = 32'h8D090004; // lw rs=8, rt=9
  localparam logic [31:0] UNK   = 32'h40000000; // opcode 010000
  localparam logic [31:0] HALT  = 32'hFD000000; // halt opcode, rs=8

  control_pipe #(
    .N_BITS      (32),
    .N_BITS_OP   (6),
    .N_BITS_REG  (5),
    .DRAIN_CYCLES(4),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .i_valid              (valid),
    .i_instruccion        (instr),
    .i_flush              (flush),
    .i_idex_memRead       (mr),
    .i_idex_rt            (ex_rt),
    .o_stall              (stall),
    .o_valid              (o_valid),
    .o_control_EX_ALUOp   (alu_op),
    .o_control_EX_ALUSrc  (alu_src),
    .o_control_EX_regDst  (reg_dst),
    .o_control_EX_jal     (jal),
    .o_control_M_branch   (branch),
    .o_control_M_memRead  (mem_read),
    .o_control_M_memWrite (mem_write),
    .o_control_WB_memtoReg(mem_to_reg),
    .o_control_WB_regWrite(reg_write),
    .o_draining           (draining),
    .o_halted             (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational stall, queue the
  // expected bundle, then compare it after the clock edge.
  task automatic apply(input string tag, input logic r, input logic v,
                       input logic [31:0] ins, input logic fl, input logic m,
                       input logic [4:0] rt, input logic exp_stall,
                       input logic [13:0] exp_out);
    logic [13:0] got;
    logic [13:0] e;
    @(negedge clk);
    rst   = r;
    valid = v;
    instr = ins;
    flush = fl;
    mr    = m;
    ex_rt = rt;
    #1;
    check({tag, "/stall"}, {31'd0, stall}, {31'd0, exp_stall});
    exp_q.push_back(exp_out);
    @(posedge clk);
    #1;
    got = {o_valid, alu_op, alu_src, reg_dst, jal, branch,
           mem_read, mem_write, mem_to_reg, reg_write, draining, halted};
    e = exp_q.pop_front();
    check({tag, "/out"}, {18'd0, got}, {18'd0, e});
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; instr = '0; flush = 1'b0; mr = 1'b0; ex_rt = '0;

    // Reset, with a would-be hazard present: no stall, all zero
    apply("reset",      1, 1, ADD_B, 0, 1, 5'd8, 0, E_BUB);
    apply("reset2",     1, 0, '0,    0, 0, 5'd0, 0, E_BUB);

    // Decode classes
    apply("add",        0, 1, ADD_A, 0, 0, 5'd0, 0, E_R);
    apply("addi",       0, 1, ADDI,  0, 0, 5'd0, 0, E_I);
    apply("beq",        0, 1, BEQ,   0, 0, 5'd0, 0, E_BR);
    apply("j",          0, 1, JMP,   0, 0, 5'd0, 0, E_J);
    apply("jal",        0, 1, JAL,   0, 0, 5'd0, 0, E_JAL);
    apply("sw",         0, 1, SW,    0, 0, 5'd0, 0, E_SW);
    apply("lw",         0, 1, LW,    0, 0, 5'd0, 0, E_LW);
    apply("unknown",    0, 1, UNK,   0, 0, 5'd0, 0, E_BUB);
    apply("not_valid",  0, 0, ADD_A, 0, 0, 5'd0, 0, E_BUB);

    // Load-use on rs: stall then the held add is latched
    apply("hz_rs",      0, 1, ADD_B, 0, 1, 5'd8,  0 | 1, E_BUB);
    apply("hz_release", 0, 1, ADD_B, 0, 0, 5'd8,  0, E_R);
    // Load-use on rt of an R-type and a store
    apply("hz_rt_r",    0, 1, ADD_B, 0, 1, 5'd10, 1, E_BUB);
    apply("hz_rt_sw",   0, 1, SW,    0, 1, 5'd9,  1, E_BUB);
    // rt is a destination for addi/lw, not a source: no stall
    apply("nohz_addi",  0, 1, ADDI,  0, 1, 5'd9,  0, E_I);
    apply("nohz_lw",    0, 1, LW,    0, 1, 5'd9,  0, E_LW);
    // J does not read rs even though those bits match
    apply("nohz_j",     0, 1, JMP,   0, 1, 5'd8,  0, E_J);
    // Flush beats stall; rt==0 never stalls; no memRead no stall
    apply("flush_hz",   0, 1, ADD_B, 1, 1, 5'd8,  0, E_BUB);
    apply("rt_zero",    0, 1, 32'h00004020, 0, 1, 5'd0, 0, E_R);
    apply("no_mr",      0, 1, ADD_B, 0, 0, 5'd8,  0, E_R);
    // Flushed halt does not start the drain
    apply("halt_flush", 0, 1, HALT,  1, 0, 5'd0,  0, E_BUB);

    // Halt accepted: four draining cycles, then sticky halted
    apply("halt",       0, 1, HALT,  0, 0, 5'd0,  0, E_DR);
    apply("drain2",     0, 1, ADD_B, 0, 1, 5'd8,  0, E_DR);
    apply("drain3",     0, 1, ADD_A, 0, 0, 5'd0,  0, E_DR);
    apply("drain4",     0, 0, '0,    0, 0, 5'd0,  0, E_DR);
    apply("halted",     0, 1, ADD_A, 0, 0, 5'd0,  0, E_HT);
    apply("halted_hz",  0, 1, ADD_B, 0, 1, 5'd8,  0, E_HT);
    apply("halted_add", 0, 1, ADD_A, 0, 0, 5'd0,  0, E_HT);
    apply("rst_halted", 1, 1, ADD_A, 0, 0, 5'd0,  0, E_BUB);
    apply("resume",     0, 1, ADD_A, 0, 0, 5'd0,  0, E_R);

    // Stalled halt does not drain; re-presented halt does; reset mid-drain
    apply("halt_stall", 0, 1, HALT,  0, 1, 5'd8,  1, E_BUB);
    apply("halt_go",    0, 1, HALT,  0, 0, 5'd8,  0, E_DR);
    apply("drain_c1",   0, 0, '0,    0, 0, 5'd0,  0, E_DR);
    apply("rst_drain",  1, 1, ADD_A, 0, 0, 5'd0,  0, E_BUB);
    apply("resume_sw",  0, 1, SW,    0, 0, 5'd0,  0, E_SW);
    apply("resume_bq",  0, 1, BEQ,   0, 1, 5'd9,  1, E_BUB);
    apply("resume_bq2", 0, 1, BEQ,   0, 0, 5'd9,  0, E_BR);

    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
